// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - miss controller and memory arbiter for split 8-line I/D caches
// Hits complete in one cycle; misses sequence evict/fill/install over one shared memory port.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_re,
  output logic [15:0] i_rdata,
  output logic        i_rdy,
  input  logic [15:0] d_addr,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_rdy,
  output logic [13:0] ic_addr,
  output logic [13:0] dc_addr,
  output logic [63:0] ic_wr_data,
  output logic [63:0] dc_wr_data,
  output logic        ic_wdirty,
  output logic        dc_wdirty,
  output logic        ic_we,
  output logic        dc_we,
  output logic        ic_re,
  output logic        dc_re,
  input  logic [63:0] ic_rd_data,
  input  logic [63:0] dc_rd_data,
  input  logic [10:0] ic_tag_out,
  input  logic [10:0] dc_tag_out,
  input  logic        ic_hit,
  input  logic        dc_hit,
  input  logic        ic_dirty,
  input  logic        dc_dirty,
  output logic [13:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy
);

  typedef enum logic [2:0] {IDLE, D_EVICT, D_FILL, D_INST, I_FILL, I_INST} state_t;

  state_t      state, state_nx;
  logic [63:0] fill_buf;
  logic        d_req;
  logic        unused_ic_status;

  function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] k);
    return line[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic [63:0] word_put(input logic [63:0] line, input logic [1:0] k,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = line;
    r[{k, 4'b0000} +: 16] = w;
    return r;
  endfunction

  // The I-cache is never written dirty, so its tag and dirty status are never consulted.
  assign unused_ic_status = ^{ic_tag_out, ic_dirty};

  assign d_req      = d_re | d_we;
  assign ic_addr    = i_addr[15:2];
  assign dc_addr    = d_addr[15:2];
  assign ic_wr_data = fill_buf;
  assign ic_wdirty  = 1'b0;
  assign mem_wdata  = dc_rd_data;
  assign i_rdata    = word_sel(ic_rd_data, i_addr[1:0]);
  assign d_rdata    = word_sel(dc_rd_data, d_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_buf <= '0;
    end else begin
      state <= state_nx;
      if ((state == D_FILL || state == I_FILL) && mem_rdy)
        fill_buf <= mem_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    i_rdy      = 1'b0;
    d_rdy      = 1'b0;
    ic_re      = 1'b0;
    dc_re      = 1'b0;
    ic_we      = 1'b0;
    dc_we      = 1'b0;
    dc_wdirty  = 1'b0;
    dc_wr_data = word_put(dc_rd_data, d_addr[1:0], d_wdata);
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = d_addr[15:2];
    unique case (state)
      IDLE: begin
        ic_re = i_re;
        dc_re = d_req;
        if (d_req && dc_hit) begin
          d_rdy = 1'b1;
          if (d_we) begin
            dc_we     = 1'b1;
            dc_wdirty = 1'b1;
          end
        end
        if (i_re && ic_hit)
          i_rdy = 1'b1;
        // D misses win; a pending I miss is re-examined on the next IDLE cycle.
        if (d_req && !dc_hit)
          state_nx = dc_dirty ? D_EVICT : D_FILL;
        else if (i_re && !ic_hit)
          state_nx = I_FILL;
      end
      D_EVICT: begin
        dc_re    = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {dc_tag_out, d_addr[4:2]};
        if (mem_rdy)
          state_nx = D_FILL;
      end
      D_FILL: begin
        mem_re = 1'b1;
        if (mem_rdy)
          state_nx = D_INST;
      end
      D_INST: begin
        dc_we      = 1'b1;
        dc_wdirty  = d_we;
        dc_wr_data = d_we ? word_put(fill_buf, d_addr[1:0], d_wdata) : fill_buf;
        state_nx   = IDLE;
      end
      I_FILL: begin
        mem_re   = 1'b1;
        mem_addr = i_addr[15:2];
        if (mem_rdy)
          state_nx = I_INST;
      end
      I_INST: begin
        ic_we    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl
// Behavioural I/D cache arrays and a fixed-latency memory surround the controller.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
  logic        i_re, d_re, d_we, i_rdy, d_rdy;
  logic [13:0] ic_addr, dc_addr, mem_addr;
  logic [63:0] ic_wr_data, dc_wr_data, ic_rd_data, dc_rd_data, mem_wdata, mem_rdata;
  logic        ic_wdirty, dc_wdirty, ic_we, dc_we, ic_re, dc_re;
  logic [10:0] ic_tag_out, dc_tag_out;
  logic        ic_hit, dc_hit, ic_dirty, dc_dirty, mem_re, mem_we, mem_rdy;

  int checks = 0;
  int errors = 0;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_re(i_re), .i_rdata(i_rdata), .i_rdy(i_rdy),
    .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rdy(d_rdy),
    .ic_addr(ic_addr), .dc_addr(dc_addr),
    .ic_wr_data(ic_wr_data), .dc_wr_data(dc_wr_data),
    .ic_wdirty(ic_wdirty), .dc_wdirty(dc_wdirty),
    .ic_we(ic_we), .dc_we(dc_we), .ic_re(ic_re), .dc_re(dc_re),
    .ic_rd_data(ic_rd_data), .dc_rd_data(dc_rd_data),
    .ic_tag_out(ic_tag_out), .dc_tag_out(dc_tag_out),
    .ic_hit(ic_hit), .dc_hit(dc_hit), .ic_dirty(ic_dirty), .dc_dirty(dc_dirty),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  // Cache arrays: index = line[2:0], tag = line[13:3], written on the low phase.
  logic [63:0] ic_line [8];
  logic [10:0] ic_tag [8];
  logic [7:0]  ic_val;
  logic [63:0] dc_line [8];
  logic [10:0] dc_tag [8];
  logic [7:0]  dc_val, dc_dty;

  assign ic_rd_data = ic_line[ic_addr[2:0]];
  assign ic_tag_out = ic_tag[ic_addr[2:0]];
  assign ic_hit     = ic_val[ic_addr[2:0]] && (ic_tag[ic_addr[2:0]] == ic_addr[13:3]);
  assign ic_dirty   = 1'b0;
  assign dc_rd_data = dc_line[dc_addr[2:0]];
  assign dc_tag_out = dc_tag[dc_addr[2:0]];
  assign dc_hit     = dc_val[dc_addr[2:0]] && (dc_tag[dc_addr[2:0]] == dc_addr[13:3]);
  assign dc_dirty   = dc_val[dc_addr[2:0]] && dc_dty[dc_addr[2:0]];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_val <= '0;
      dc_val <= '0;
      dc_dty <= '0;
    end else begin
      if (ic_we) begin
        ic_line[ic_addr[2:0]] <= ic_wr_data;
        ic_tag[ic_addr[2:0]]  <= ic_addr[13:3];
        ic_val[ic_addr[2:0]]  <= 1'b1;
      end
      if (dc_we) begin
        dc_line[dc_addr[2:0]] <= dc_wr_data;
        dc_tag[dc_addr[2:0]]  <= dc_addr[13:3];
        dc_val[dc_addr[2:0]]  <= 1'b1;
        dc_dty[dc_addr[2:0]]  <= dc_wdirty;
      end
    end
  end

  // Memory: untouched line a holds word k = {k, a}; mem_rdy on the lat-th active cycle.
  function automatic logic [63:0] pat(input logic [13:0] a);
    return {2'b11, a, 2'b10, a, 2'b01, a, 2'b00, a};
  endfunction

  logic [63:0]    wmem [16384];
  logic [16383:0] wv = '0;
  int             lat = 3;
  int             cnt = 0;

  assign mem_rdy   = (mem_re || mem_we) && (cnt == lat - 1);
  assign mem_rdata = wv[mem_addr] ? wmem[mem_addr] : pat(mem_addr);

  always @(posedge clk) begin
    if (!(mem_re || mem_we) || mem_rdy) cnt <= 0;
    else cnt <= cnt + 1;
    if (mem_we && mem_rdy) begin
      wmem[mem_addr] <= mem_wdata;
      wv[mem_addr]   <= 1'b1;
    end
  end

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [63:0] data;
  } xact_t;

  xact_t       log_q[$];
  logic [64:0] dw_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (mem_re || mem_we)) begin
      chk("mem_excl", 64'(mem_re && mem_we), 64'd0);
      if (mem_rdy) log_q.push_back('{mem_we, mem_addr, mem_wdata});
    end
    if (rst_n && dc_we) dw_q.push_back({dc_wdirty, dc_wr_data});
  end

  task automatic chk_x(input string tag, input int i, input logic we,
                       input logic [13:0] a, input logic [63:0] dat);
    if (log_q.size() > i) begin
      chk({tag, "_we"}, 64'(log_q[i].we), 64'(we));
      chk({tag, "_addr"}, 64'(log_q[i].addr), 64'(a));
      if (we) chk({tag, "_data"}, log_q[i].data, dat);
    end else begin
      chk({tag, "_cnt"}, 64'(log_q.size()), 64'(i + 1));
    end
  endtask

  // Issue one request, count cycles from the request cycle to rdy, then release it.
  task automatic access(input logic d, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, output int n, output logic [15:0] rd,
                        output logic wflags);
    @(posedge clk); #2;
    if (d) begin
      d_addr = a; d_re = !wr; d_we = wr; d_wdata = wd;
    end else begin
      i_addr = a; i_re = 1'b1;
    end
    #1;
    n = 0;
    while (!(d ? d_rdy : i_rdy) && n < 50) begin
      @(posedge clk); #3;
      n++;
    end
    rd     = d ? d_rdata : i_rdata;
    wflags = dc_we & dc_wdirty;
    @(posedge clk); #2;
    i_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
  endtask

  int          n, dn, inn, cyc;
  logic [15:0] rd, drd, ird;
  logic        wf;

  initial begin
    i_re = 1'b1; d_re = 1'b1; d_we = 1'b0;
    i_addr = 16'h0040; d_addr = 16'h0123; d_wdata = 16'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_i_rdy", 64'(i_rdy), 64'd0);
    chk("rst_d_rdy", 64'(d_rdy), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_ic_we", 64'(ic_we), 64'd0);
    chk("rst_dc_we", 64'(dc_we), 64'd0);
    i_re = 1'b0; d_re = 1'b0;
    #19 rst_n = 1'b1;

    // Clean I miss, N = 3
    lat = 3;
    log_q.delete();
    access(1'b0, 1'b0, 16'h0040, 16'h0, n, rd, wf);
    chk("i_miss_lat", 64'(n), 64'd5);
    chk("i_miss_data", 64'(rd), 64'h0010);
    chk_x("i_miss_rd", 0, 1'b0, 14'h0010, 64'h0);

    // Load miss, store hit, read-back
    log_q.delete();
    access(1'b1, 1'b0, 16'h0123, 16'h0, n, rd, wf);
    chk("ld_miss_lat", 64'(n), 64'd5);
    chk("ld_miss_data", 64'(rd), 64'hC048);
    chk_x("ld_miss_rd", 0, 1'b0, 14'h0048, 64'h0);
    access(1'b1, 1'b1, 16'h0123, 16'hBEEF, n, rd, wf);
    chk("st_hit_lat", 64'(n), 64'd0);
    chk("st_hit_we_dirty", 64'(wf), 64'd1);
    access(1'b1, 1'b0, 16'h0123, 16'h0, n, rd, wf);
    chk("ld_after_st_lat", 64'(n), 64'd0);
    chk("ld_after_st_data", 64'(rd), 64'hBEEF);
    access(1'b1, 1'b0, 16'h0121, 16'h0, n, rd, wf);
    chk("ld_word1_data", 64'(rd), 64'h4048);
    access(1'b1, 1'b0, 16'h0122, 16'h0, n, rd, wf);
    chk("ld_word2_data", 64'(rd), 64'h8048);

    // Dirty conflict miss: evict then fill
    log_q.delete();
    access(1'b1, 1'b0, 16'h2123, 16'h0, n, rd, wf);
    chk("dirty_miss_lat", 64'(n), 64'd8);
    chk("dirty_miss_data", 64'(rd), 64'hC848);
    chk_x("evict", 0, 1'b1, 14'h0048, 64'hBEEF_8048_4048_0048);
    chk_x("evict_fill", 1, 1'b0, 14'h0848, 64'h0);

    // Simultaneous I and D miss, N = 2
    lat = 2;
    log_q.delete();
    @(posedge clk); #2;
    i_addr = 16'h0100; i_re = 1'b1; d_addr = 16'h0044; d_re = 1'b1;
    #1;
    cyc = 0; dn = -1; inn = -1; drd = '0; ird = '0;
    while ((dn < 0 || inn < 0) && cyc < 60) begin
      if (d_rdy && dn < 0) begin dn = cyc; drd = d_rdata; end
      if (i_rdy && inn < 0) begin inn = cyc; ird = i_rdata; end
      @(posedge clk); #2;
      if (dn >= 0) d_re = 1'b0;
      if (inn >= 0) i_re = 1'b0;
      #1;
      cyc++;
    end
    i_re = 1'b0; d_re = 1'b0;
    chk("arb_d_lat", 64'(dn), 64'd4);
    chk("arb_i_lat", 64'(inn), 64'd8);
    chk("arb_d_data", 64'(drd), 64'h0011);
    chk("arb_i_data", 64'(ird), 64'h0040);
    chk_x("arb_first", 0, 1'b0, 14'h0011, 64'h0);
    chk_x("arb_second", 1, 1'b0, 14'h0040, 64'h0);

    // Store miss with N = 1, then conflict eviction of the dirty line
    lat = 1;
    log_q.delete();
    dw_q.delete();
    access(1'b1, 1'b1, 16'h0301, 16'hCAFE, n, rd, wf);
    chk("st_miss_lat", 64'(n), 64'd3);
    chk_x("st_miss_rd", 0, 1'b0, 14'h00C0, 64'h0);
    chk("st_inst_cnt_ok", 64'(dw_q.size() >= 1), 64'd1);
    if (dw_q.size() >= 1)
      chk("st_inst_line", 64'(dw_q[0]), {1'b1, 64'hC0C0_80C0_CAFE_00C0});
    access(1'b1, 1'b0, 16'h0301, 16'h0, n, rd, wf);
    chk("st_miss_rb1", 64'(rd), 64'hCAFE);
    access(1'b1, 1'b0, 16'h0300, 16'h0, n, rd, wf);
    chk("st_miss_rb0", 64'(rd), 64'h00C0);
    log_q.delete();
    dw_q.delete();
    access(1'b1, 1'b0, 16'h0020, 16'h0, n, rd, wf);
    chk("n1_dirty_lat", 64'(n), 64'd4);
    chk("n1_dirty_data", 64'(rd), 64'h0008);
    chk_x("n1_evict", 0, 1'b1, 14'h00C0, 64'hC0C0_80C0_CAFE_00C0);
    chk_x("n1_fill", 1, 1'b0, 14'h0008, 64'h0);
    chk("ld_inst_cnt_ok", 64'(dw_q.size() >= 1), 64'd1);
    if (dw_q.size() >= 1)
      chk("ld_inst_line", 64'(dw_q[0]), {1'b0, 64'hC008_8008_4008_0008});

    // Reset in the middle of D_FILL, N = 5
    lat = 5;
    log_q.delete();
    dw_q.delete();
    @(posedge clk); #2;
    d_addr = 16'h0444; d_re = 1'b1;
    #1;
    chk("abort_miss_rdy", 64'(d_rdy), 64'd0);
    @(posedge clk); #3;
    chk("abort_fill_re", 64'(mem_re), 64'd1);
    chk("abort_fill_addr", 64'(mem_addr), 64'h0111);
    rst_n = 1'b0;
    #1;
    chk("abort_re_drop", 64'(mem_re), 64'd0);
    chk("abort_we_drop", 64'(mem_we), 64'd0);
    chk("abort_d_rdy", 64'(d_rdy), 64'd0);
    @(posedge clk); #3;
    chk("abort_re_held", 64'(mem_re), 64'd0);
    d_re = 1'b0;
    rst_n = 1'b1;
    chk("abort_no_install", 64'(dw_q.size()), 64'd0);
    access(1'b1, 1'b0, 16'h0444, 16'h0, n, rd, wf);
    chk("abort_retry_lat", 64'(n), 64'd7);
    chk("abort_retry_data", 64'(rd), 64'h0111);
    chk("abort_log_cnt", 64'(log_q.size()), 64'd1);
    chk_x("abort_retry_rd", 0, 1'b0, 14'h0111, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss controller and memory arbiter for the instruction and data caches of the 5-stage pipelined CPU. It services hits in one cycle, sequences line fills and dirty evictions for both 8-line direct-mapped caches, and shares the single 64-bit unified memory port between them. It sits between the IF/MEM pipeline stages, the two cache instances and main memory. It stalls a stage by holding its ready output low.

## Interface
- Parameters: none. Fixed geometry: 16-bit word address; cache line address = addr[15:2]; word select = addr[1:0].
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_addr  in  16  fetch word address
- i_re  in  1  fetch request
- i_rdata  out  16  fetched instruction word
- i_rdy  out  1  fetch complete this cycle
- d_addr  in  16  load/store word address
- d_re / d_we  in  1 each  load / store request
- d_wdata  in  16  store word
- d_rdata  out  16  load word
- d_rdy  out  1  load/store complete this cycle
- ic_addr, dc_addr  out  14  cache line address
- ic_wr_data, dc_wr_data  out  64  line to install
- ic_wdirty, dc_wdirty  out  1  dirty bit to install
- ic_we, dc_we, ic_re, dc_re  out  1  cache strobes
- ic_rd_data, dc_rd_data  in  64  cache line
- ic_tag_out, dc_tag_out  in  11  resident tag
- ic_hit, dc_hit, ic_dirty, dc_dirty  in  1  cache status
- mem_addr  out  14  memory line address
- mem_re / mem_we  out  1  memory read / write strobe
- mem_wdata  out  64  eviction data
- mem_rdata  in  64  fill data
- mem_rdy  in  1  memory access done

## Operation
- States:
  - IDLE
  - D_EVICT: write the dirty D line back to memory.
  - D_FILL: read the D line from memory.
  - D_INST: install the D line in the cache.
  - I_FILL: read the I line from memory.
  - I_INST: install the I line in the cache.
- Requesters hold addr, data and strobes stable until their rdy output is high.
- Concurrent d_re and d_we are treated as a store.
- Word mux: word k = line[16k+15:16k], with k = addr[1:0].
- Strobes in IDLE:
  - ic_re = i_re.
  - dc_re = d_re | d_we.
  - Cache addresses are taken from the live requester address, bits [15:2].
- Read hit: rdy = 1 in the same cycle; rdata is the selected word.
- Write hit:
  - dc_we = 1 and dc_wdirty = 1.
  - dc_wr_data = dc_rd_data with word k replaced by d_wdata.
  - d_rdy = 1 in the same cycle.
- Arbitration in IDLE: a D miss has priority over an I miss. An I miss waits until the D sequence finishes and the controller returns to IDLE.
- D miss, resident line valid and dirty:
  - Go to D_EVICT.
  - mem_we = 1, mem_addr = {dc_tag_out, d_addr[4:2]}, mem_wdata = dc_rd_data.
  - Hold until mem_rdy, then go to D_FILL.
- D miss, line clean or invalid: go directly to D_FILL.
- D_FILL:
  - mem_re = 1, mem_addr = d_addr[15:2].
  - On mem_rdy, latch mem_rdata into the fill buffer and go to D_INST.
- D_INST (one cycle):
  - dc_we = 1, dc_wr_data = fill buffer.
  - For a store, word k of the fill buffer is replaced by d_wdata and dc_wdirty = 1; otherwise dc_wdirty = 0.
  - Next state is IDLE; the retried access then hits.
- I miss: I_FILL (mem_re, mem_addr = i_addr[15:2]), then I_INST (ic_we, ic_wdirty = 0), then IDLE. The I-cache is never dirty.
- i_rdy and d_rdy are 0 in every state except IDLE.

## Timing
- Reset (async, immediate):
  - State = IDLE; fill buffer cleared.
  - mem_re, mem_we, ic_we, dc_we = 0.
  - i_rdy, d_rdy = 0, because both caches clear their valid bits on the same rst_n.
  - rdata outputs are don't-care while rdy = 0.
- Reset in the middle of a sequence aborts it. Memory strobes drop asynchronously and no partial line is installed.
- mem_re and mem_we are never high together. They stay high, with address and data stable, until the cycle in which mem_rdy = 1 is sampled.
- mem_rdy outside D_EVICT, D_FILL and I_FILL is ignored.
- Cache writes land on the low phase of the asserting cycle, so the hit or write in the cycle after INST sees the new line.
- Latency with memory latency N (cycles until mem_rdy):
  - Clean miss: rdy in cycle N+2 after the miss cycle.
  - Dirty D miss: rdy in cycle 2N+2.
  - I miss blocked behind a D miss: the D sequence, plus one IDLE cycle, plus N+2.
- An I hit and a D hit in the same cycle both complete; the caches are independent.
- mem_rdy in the first cycle of a memory state (N = 1) is legal.

## Test plan
- Reset, then i_re at 0x0040 with N = 3:
  - i_rdy low for 5 cycles (miss cycle + 3 fill + 1 install), high on the 6th.
  - mem_addr = 0x0010; i_rdata = word 0 of the fill line.
- Load 0x0123 then store 0x0123 = 0xBEEF:
  - The store completes in one cycle with dc_we and dc_wdirty = 1.
  - A following load returns 0xBEEF; the other three words are unchanged.
- Load 0x2123 (same index as 0x0123, different tag) after the dirty store:
  - mem_we with mem_addr = 0x0048 and the dirty line, then mem_re with mem_addr = 0x0848.
  - d_rdy after 2N+2 cycles.
- I miss and D miss in the same cycle:
  - D is serviced first; mem_addr shows the D line before the I line.
  - i_rdy rises only after d_rdy.
- Store miss at 0x0301:
  - Fill, then install with word 1 = d_wdata and dc_wdirty = 1.
  - A later conflict miss on index 0 triggers an eviction.
- rst_n low during D_FILL:
  - mem_re drops within the reset assertion and the state returns to IDLE.
  - After release, a load to the same address misses again.
